iv_solver: RTL
==============

Name: iv_solver

Overview:
Inverse of the Black-Scholes pricing path: given a market option price, it recovers implied volatility (Q16.16) by bisection on sigma. It acts as the initiator toward the existing pricing pipeline (d1d2 -> norm -> OptionPrice, wrapped with a start/done pair). It issues one sigma per iteration, waits for the price, then narrows the bracket. It sits beside the pricer in the top level and shares the spot/strike/timetm/rate/otype nets with it.

Parameters:
WIDTH, 32, datapath width (Q16.16 signed)
SIGMA_LO, 32'h0000_0000, initial lower sigma bound (0.0)
SIGMA_HI, 32'h0004_0000, initial upper sigma bound (4.0)
TOL, 64, price tolerance in LSBs (~0.001)
MAX_ITER, 20, maximum pricer evaluations in the bisection phase
PX_TIMEOUT, 1024, maximum cycles to wait for px_done

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
target_price  in  WIDTH  market price to match, Q16.16
px_start  out  1  one-cycle pulse to the pricer
px_sigma  out  WIDTH  sigma under evaluation, held stable from px_start until px_done
px_price  in  WIDTH  pricer result, valid when px_done=1
px_done  in  1  pricer completion pulse
busy  out  1  high from the cycle after an accepted start through the DONE cycle
done  out  1  one-cycle result pulse
sigma_out  out  WIDTH  result sigma; held until the next done
err_code  out  2  0=OK, 1=MAXITER, 2=TIMEOUT, 3=RANGE
iter_count  out  8  number of pricer evaluations used

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0. A px_done arriving after reset is ignored.
- IDLE: on start=1, latch target_price, set lo=SIGMA_LO, hi=SIGMA_HI, clear iteration and timeout counters, go to ISSUE. start outside IDLE is ignored.
- ISSUE (1 cycle): px_sigma = mid = (lo+hi)>>1, computed in WIDTH+1 unsigned bits so it cannot overflow. Assert px_start for this cycle only, increment the iteration counter, go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - On px_done, capture px_price and go to UPDATE.
  - If the counter reaches PX_TIMEOUT first, go to DONE with err=TIMEOUT and sigma_out=mid.
  - If px_done and the timeout fall in the same cycle, px_done wins.
- UPDATE (1 cycle): diff = px_price - target, computed as WIDTH+1 signed.
  - If |diff| <= TOL: go to DONE, err=OK, sigma_out=mid.
  - Otherwise: if diff<0 then lo=mid, else hi=mid.
  - If the iteration counter has reached MAX_ITER: go to DONE, err=MAXITER, sigma_out=mid. Otherwise go to ISSUE.
- DONE (1 cycle): done=1; sigma_out, err_code and iter_count register here and hold until the next done. Go to IDLE. A start is accepted on the following IDLE cycle, so done-to-next-start latency is 1 cycle.
- Monotonicity: price increases with sigma for both calls and puts, so the update rule does not depend on otype.
- Latency per iteration: 3 cycles plus the pricer latency.
- Reset mid-operation: returns to IDLE immediately; no done pulse is generated.

Optional Feature:
- Macro IV_BRACKET_CHECK_EN.
- Defined: two states, CHK_LO and CHK_HI, are inserted before the first ISSUE. They price SIGMA_LO and SIGMA_HI using the same ISSUE/WAIT timing, and both evaluations count in iter_count.
  - If target < price(lo)-TOL or target > price(hi)+TOL: DONE with err=RANGE and sigma_out=0.
  - If either bound price is already within TOL of the target: DONE with err=OK and that bound as sigma_out.
- Undefined: no bracket check; err_code never takes the value 3.

Decomposition:
- Package iv_pkg holds:
  - the state enum (IDLE, CHK_LO, CHK_HI, ISSUE, WAIT, UPDATE, DONE);
  - the err_code constants;
  - the Q16.16 constants ONE=32'h0001_0000 and default SIGMA_HI.
- One sub-module, iv_px_if, owns the px_start pulse, px_sigma hold, timeout counter and the px_done capture register. The FSM and bracket registers stay in iv_solver.

Test Plan:
1. Linear stub pricer (px_price=px_sigma, 4-cycle latency), target=32'h0000_8000 -> mids are 0x20000, 0x10000, 0x8000; done with sigma_out=0x8000, err=0, iter_count=3.
2. Behavioural BS pricer, call, S=K=100, T=1, r=0.05, target=684890 (10.4506) -> done within 20 iterations, |sigma_out-13107| <= 66, err=0.
3. Pricer that never asserts px_done -> exactly PX_TIMEOUT cycles after px_start, done=1, err=2, sigma_out=0x20000, iter_count=1.
4. Assert reset during WAIT of iteration 2, then a late px_done -> all outputs 0, no done pulse, and a new start works normally.
5. start pulses while busy, and start in the DONE cycle -> both ignored; start on the next IDLE cycle is accepted and px_start follows 1 cycle later.
6. With IV_BRACKET_CHECK_EN, linear stub, target=32'h0005_0000 -> err=3, sigma_out=0, iter_count=2. Without the macro, the same stimulus gives err=1 and iter_count=20.

Source files
------------

// File: rtl/iv_pkg.sv
// Shared types and constants for the implied-volatility bisection solver.
// Q16.16 fixed point throughout; error codes match the err_code output encoding.
package iv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_LO,
        CHK_HI,
        ISSUE,
        WAIT,
        UPDATE,
        DONE
    } state_t;

    // Tracks which evaluation the pending price belongs to when bracket checking is built in.
    typedef enum logic [1:0] {
        PH_LO,
        PH_HI,
        PH_BIS
    } phase_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_MAXITER = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_RANGE   = 2'd3;

    localparam logic [31:0] ONE          = 32'h0001_0000;
    localparam logic [31:0] SIGMA_HI_DEF = 32'h0004_0000;

endpackage

// File: rtl/iv_px_if.sv
// Pricer handshake side of the solver: px_start pulse, px_sigma hold,
// per-request timeout counter and capture of the returned price.
module iv_px_if
    import iv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PX_TIMEOUT = 1024
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_issue,
    input  logic             i_waiting,
    input  logic [WIDTH-1:0] i_sigma,
    input  logic [WIDTH-1:0] i_px_price,
    input  logic             i_px_done,
    output logic             o_px_start,
    output logic [WIDTH-1:0] o_px_sigma,
    output logic             o_got_price,
    output logic             o_timeout,
    output logic [WIDTH-1:0] o_price
);

    localparam int CW = $clog2(PX_TIMEOUT + 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sigma;
    logic [WIDTH-1:0] r_price;

    // The counter starts at 1 on the issue cycle so it equals cycles elapsed since px_start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_sigma <= '0;
            r_price <= '0;
        end else begin
            if (i_issue) begin
                r_sigma <= i_sigma;
                r_cnt   <= CW'(1);
            end else if (i_waiting) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_waiting && i_px_done) begin
                r_price <= i_px_price;
            end
        end
    end

    assign o_px_start  = i_issue;
    assign o_px_sigma  = i_issue ? i_sigma : r_sigma;
    assign o_got_price = i_waiting & i_px_done;
    assign o_timeout   = i_waiting & ~i_px_done & (r_cnt == CW'(PX_TIMEOUT - 1));
    assign o_price     = r_price;

endmodule

// File: rtl/iv_solver.sv
// Implied-volatility solver: bisects sigma against an external pricer until the
// price matches target within TOL. Optional bracket pre-check via IV_BRACKET_CHECK_EN.
module iv_solver
    import iv_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] SIGMA_LO   = '0,
    parameter logic [WIDTH-1:0] SIGMA_HI   = SIGMA_HI_DEF,
    parameter int               TOL        = 64,
    parameter int               MAX_ITER   = 20,
    parameter int               PX_TIMEOUT = 1024
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] target_price,
    output logic             px_start,
    output logic [WIDTH-1:0] px_sigma,
    input  logic [WIDTH-1:0] px_price,
    input  logic             px_done,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sigma_out,
    output logic [1:0]       err_code,
    output logic [7:0]       iter_count
);

`ifdef IV_BRACKET_CHECK_EN
    localparam int     CHK_EVALS   = 2;
    localparam state_t FIRST_STATE = CHK_LO;
`else
    localparam int     CHK_EVALS   = 0;
    localparam state_t FIRST_STATE = ISSUE;
`endif

    localparam logic signed [WIDTH:0] TOL_S = (WIDTH+1)'(TOL);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_target, r_lo, r_hi;
    logic [7:0]       r_iter;
    logic [WIDTH-1:0] r_sigma_out;
    logic [1:0]       r_err;
    logic [7:0]       r_iter_out;
`ifdef IV_BRACKET_CHECK_EN
    phase_t           r_phase;
`endif

    logic [WIDTH:0]        w_sum;
    logic [WIDTH-1:0]      w_mid;
    logic signed [WIDTH:0] w_diff;
    logic                  w_in_tol, w_last;
    logic                  w_issue, w_waiting, w_got_price, w_timeout;
    logic [WIDTH-1:0]      w_issue_sigma, w_px_sigma, w_price;
    logic                  w_lower, w_upper;
    logic [WIDTH-1:0]      w_res_sigma;
    logic [1:0]            w_res_err;

    // One extra bit keeps lo+hi from wrapping before the halving.
    assign w_sum     = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid     = w_sum[WIDTH:1];
    assign w_diff    = $signed({w_price[WIDTH-1], w_price}) - $signed({r_target[WIDTH-1], r_target});
    assign w_in_tol  = (w_diff <= TOL_S) && (w_diff >= -TOL_S);
    assign w_last    = (r_iter >= 8'(MAX_ITER + CHK_EVALS));
    assign w_waiting = (r_state == WAIT);

    iv_px_if #(
        .WIDTH      (WIDTH),
        .PX_TIMEOUT (PX_TIMEOUT)
    ) u_px_if (
        .clk         (clk),
        .reset       (reset),
        .i_issue     (w_issue),
        .i_waiting   (w_waiting),
        .i_sigma     (w_issue_sigma),
        .i_px_price  (px_price),
        .i_px_done   (px_done),
        .o_px_start  (px_start),
        .o_px_sigma  (w_px_sigma),
        .o_got_price (w_got_price),
        .o_timeout   (w_timeout),
        .o_price     (w_price)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The held px_sigma is the sigma just priced, so it doubles as the result candidate.
    always_comb begin
        w_next        = r_state;
        w_issue       = 1'b0;
        w_issue_sigma = w_mid;
        w_lower       = 1'b0;
        w_upper       = 1'b0;
        w_res_sigma   = w_px_sigma;
        w_res_err     = ERR_OK;
        case (r_state)
            IDLE: begin
                if (start) w_next = FIRST_STATE;
            end
            CHK_LO: begin
                w_issue       = 1'b1;
                w_issue_sigma = SIGMA_LO;
                w_next        = WAIT;
            end
            CHK_HI: begin
                w_issue       = 1'b1;
                w_issue_sigma = SIGMA_HI;
                w_next        = WAIT;
            end
            ISSUE: begin
                w_issue = 1'b1;
                w_next  = WAIT;
            end
            WAIT: begin
                if (w_got_price) begin
                    w_next = UPDATE;
                end else if (w_timeout) begin
                    w_next    = DONE;
                    w_res_err = ERR_TIMEOUT;
                end
            end
            UPDATE: begin
`ifdef IV_BRACKET_CHECK_EN
                if (r_phase == PH_LO) begin
                    if (w_diff > TOL_S) begin
                        w_next      = DONE;
                        w_res_err   = ERR_RANGE;
                        w_res_sigma = '0;
                    end else if (w_in_tol) begin
                        w_next = DONE;
                    end else begin
                        w_next = CHK_HI;
                    end
                end else if (r_phase == PH_HI) begin
                    if (w_diff < -TOL_S) begin
                        w_next      = DONE;
                        w_res_err   = ERR_RANGE;
                        w_res_sigma = '0;
                    end else if (w_in_tol) begin
                        w_next = DONE;
                    end else begin
                        w_next = ISSUE;
                    end
                end else
`endif
                if (w_in_tol) begin
                    w_next = DONE;
                end else begin
                    if (w_diff < 0) w_lower = 1'b1;
                    else            w_upper = 1'b1;
                    if (w_last) begin
                        w_next    = DONE;
                        w_res_err = ERR_MAXITER;
                    end else begin
                        w_next = ISSUE;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Result registers load on entry to DONE so they are valid alongside the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_target    <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_iter      <= '0;
            r_sigma_out <= '0;
            r_err       <= ERR_OK;
            r_iter_out  <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_target <= target_price;
                r_lo     <= SIGMA_LO;
                r_hi     <= SIGMA_HI;
                r_iter   <= '0;
            end
            if (w_issue) r_iter <= r_iter + 8'd1;
            if (w_lower) r_lo <= w_px_sigma;
            if (w_upper) r_hi <= w_px_sigma;
            if (w_next == DONE) begin
                r_sigma_out <= w_res_sigma;
                r_err       <= w_res_err;
                r_iter_out  <= r_iter;
            end
        end
    end

`ifdef IV_BRACKET_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= PH_LO;
        end else if (w_issue) begin
            r_phase <= (r_state == CHK_LO) ? PH_LO : (r_state == CHK_HI) ? PH_HI : PH_BIS;
        end
    end
`endif

    assign px_sigma   = w_px_sigma;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign sigma_out  = r_sigma_out;
    assign err_code   = r_err;
    assign iter_count = r_iter_out;

endmodule
